write_control: RTL and testbench

Write-side counterpart of the acquisition controller: replays a stored flux-timing stream from the sample RAM to the floppy drive as write pulses. It arms on START, waits for a programmable number of index events, asserts write gate, then emits one FD_WRDATA pulse per timing record until the stream ends or a programmed number of stop index events elapses. It sits between the RAM read port and the drive output pins, in the CLK_MASTER domain.

---
 rtl/write_control_pkg.sv | 20 ++
 rtl/write_pulse_stretch.sv | 38 +++
 rtl/write_control.sv | 190 +++++++++++++++++++
 tb/tb_write_control.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_control_pkg.sv
// Shared state encoding and timing-record field positions for the flux write path.
package write_control_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StLead,
      StFetch,
      StDelay,
      StPulse
   } wc_state_e;

   localparam int unsigned REC_PULSE_BIT = 7;
   localparam int unsigned REC_DELAY_MSB = 6;

   function automatic logic is_writing(input wc_state_e s);
      return (s == StLead) || (s == StFetch) || (s == StDelay) || (s == StPulse);
   endfunction

endpackage

// File: rtl/write_pulse_stretch.sv
// Load/count-down pulse generator driving FD_WRDATA; the output register trails the
// count by one cycle, so the pulse starts the cycle after the load.
module write_pulse_stretch #(
   parameter logic [7:0] PULSE_WIDTH = 8'd4
) (
   input  logic CLK_MASTER,
   input  logic RESET_N,
   input  logic load,
   input  logic kill,
   output logic last,
   output logic pulse
);

   logic [7:0] count_q;
   logic       pulse_q;

   always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
      if (!RESET_N) begin
         count_q <= 8'd0;
         pulse_q <= 1'b0;
      end else if (kill) begin
         count_q <= 8'd0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= (count_q != 8'd0);
         if (load) begin
            count_q <= PULSE_WIDTH;
         end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
         end
      end
   end

   // A zero width still releases the PULSE state after one cycle.
   assign last  = (count_q <= 8'd1);
   assign pulse = pulse_q;

endmodule

// File: rtl/write_control.sv
// Replays stored flux-timing records from the sample RAM to the drive as write pulses,
// framed by index-counted start/stop and a write-gate lead-in.
module write_control
   import write_control_pkg::*;
#(
   parameter logic [7:0] PULSE_WIDTH = 8'd4,
   parameter logic [7:0] GATE_LEAD   = 8'd16
) (
   input  logic       CLK_MASTER,
   input  logic       RESET_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic       FD_INDEX_IN,
   input  logic       CKE_TIMEBASE,
   input  logic [7:0] WR_START_MASK,
   input  logic [7:0] WR_START_NUM,
   input  logic [7:0] WR_STOP_MASK,
   input  logic [7:0] WR_STOP_NUM,
   input  logic [7:0] RD_DATA,
   input  logic       RD_VALID,
   output logic       RD_ACK,
   output logic       FD_WRGATE,
   output logic       FD_WRDATA,
   output logic       WAITING,
   output logic       WRITING,
   output logic       UNDERRUN
);

   wc_state_e              state_q, state_d;
   logic                   idx_q;
   logic                   index_evt;
   logic                   stop_evt;
   logic [7:0]             scount_q, scount_d;
   logic [7:0]             ecount_q, ecount_d;
   logic [7:0]             lead_q, lead_d;
   logic [REC_DELAY_MSB:0] dly_q, dly_d;
   logic                   rec_pulse_q, rec_pulse_d;
   logic                   underrun_q, underrun_d;
   logic                   rd_ack_q, waiting_q, writing_q;
   logic                   pulse_load, pulse_kill, pulse_last, pulse_out;
   logic                   unused_mask_bits;

   assign unused_mask_bits = ^{WR_START_MASK[7:1], WR_STOP_MASK[7:1]};

   assign index_evt = FD_INDEX_IN & ~idx_q;
   assign stop_evt  = is_writing(state_q) && WR_STOP_MASK[0] && index_evt &&
                      (ecount_q == 8'd0);

   always_comb begin
      state_d     = state_q;
      scount_d    = scount_q;
      ecount_d    = ecount_q;
      lead_d      = lead_q;
      dly_d       = dly_q;
      rec_pulse_d = rec_pulse_q;
      underrun_d  = underrun_q;
      pulse_load  = 1'b0;
      pulse_kill  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d    = StWait;
               scount_d   = WR_START_NUM;
               ecount_d   = WR_STOP_NUM;
               underrun_d = 1'b0;
            end
         end
         StWait: begin
            if (!WR_START_MASK[0]) begin
               state_d = StLead;
               lead_d  = GATE_LEAD;
            end else if (index_evt) begin
               if (scount_q != 8'd0) begin
                  scount_d = scount_q - 8'd1;
               end else begin
                  state_d = StLead;
                  lead_d  = GATE_LEAD;
               end
            end
         end
         StLead: begin
            if (lead_q <= 8'd1) begin
               state_d = StFetch;
               lead_d  = 8'd0;
            end else begin
               lead_d = lead_q - 8'd1;
            end
         end
         StFetch: begin
            if (RD_VALID) begin
               state_d     = StDelay;
               dly_d       = RD_DATA[REC_DELAY_MSB:0];
               rec_pulse_d = RD_DATA[REC_PULSE_BIT];
            end else begin
               state_d = StIdle;
               if (WR_STOP_MASK[0]) begin
                  underrun_d = 1'b1;
               end
            end
         end
         StDelay: begin
            if (dly_q == '0) begin
               if (rec_pulse_q) begin
                  state_d    = StPulse;
                  pulse_load = 1'b1;
               end else begin
                  state_d = StFetch;
               end
            end else if (CKE_TIMEBASE) begin
               dly_d = dly_q - 1'b1;
            end
         end
         StPulse: begin
            if (pulse_last) begin
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase

      // Index-count stop outranks the normal flow, including end-of-stream in FETCH.
      if (is_writing(state_q) && WR_STOP_MASK[0] && index_evt && (ecount_q != 8'd0)) begin
         ecount_d = ecount_q - 8'd1;
      end
      if (stop_evt) begin
         state_d    = StIdle;
         underrun_d = underrun_q;
         pulse_load = 1'b0;
         pulse_kill = 1'b1;
      end

      if (ABORT) begin
         state_d    = StIdle;
         scount_d   = scount_q;
         ecount_d   = ecount_q;
         underrun_d = underrun_q;
         pulse_load = 1'b0;
         pulse_kill = 1'b1;
      end
   end

   always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         idx_q       <= 1'b0;
         scount_q    <= 8'd0;
         ecount_q    <= 8'd0;
         lead_q      <= 8'd0;
         dly_q       <= '0;
         rec_pulse_q <= 1'b0;
         underrun_q  <= 1'b0;
         rd_ack_q    <= 1'b0;
         waiting_q   <= 1'b0;
         writing_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= FD_INDEX_IN;
         scount_q    <= scount_d;
         ecount_q    <= ecount_d;
         lead_q      <= lead_d;
         dly_q       <= dly_d;
         rec_pulse_q <= rec_pulse_d;
         underrun_q  <= underrun_d;
         // Pop lands on the edge after the record is latched, while the head is still valid.
         rd_ack_q    <= (state_q == StFetch) && (state_d == StDelay);
         waiting_q   <= (state_d == StWait);
         writing_q   <= is_writing(state_d);
      end
   end

   write_pulse_stretch #(
      .PULSE_WIDTH(PULSE_WIDTH)
   ) u_pulse_stretch (
      .CLK_MASTER(CLK_MASTER),
      .RESET_N   (RESET_N),
      .load      (pulse_load),
      .kill      (pulse_kill),
      .last      (pulse_last),
      .pulse     (pulse_out)
   );

   assign RD_ACK    = rd_ack_q;
   assign FD_WRGATE = writing_q;
   assign FD_WRDATA = pulse_out;
   assign WAITING   = waiting_q;
   assign WRITING   = writing_q;
   assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_write_control.sv
// Directed bench for write_control: a RAM model feeds records, a scoreboard holds the
// expected RD_ACK cycles and FD_WRDATA pulse starts/widths derived from the record stream.
module tb_write_control;

   localparam logic [7:0] PW = 8'd4;
   localparam logic [7:0] GL = 8'd16;

   typedef logic [7:0] rec_t;
   typedef struct {
      int rise;
      int width;
   } pulse_t;

   logic       CLK_MASTER = 1'b0;
   logic       RESET_N = 1'b0;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic       FD_INDEX_IN = 1'b0;
   logic       CKE_TIMEBASE = 1'b1;
   logic [7:0] WR_START_MASK = 8'd0;
   logic [7:0] WR_START_NUM = 8'd0;
   logic [7:0] WR_STOP_MASK = 8'd0;
   logic [7:0] WR_STOP_NUM = 8'd0;
   logic [7:0] RD_DATA = 8'd0;
   logic       RD_VALID = 1'b0;
   logic       RD_ACK, FD_WRGATE, FD_WRDATA, WAITING, WRITING, UNDERRUN;

   pulse_t exp_rise[$];
   int     exp_ack[$];
   rec_t   ram[$];
   int     cyc = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   int     hi = 0;
   int     cur_w = 0;
   logic   wr_prev = 1'b0;
   logic   ack_pending = 1'b0;

   write_control #(
      .PULSE_WIDTH(PW),
      .GATE_LEAD  (GL)
   ) dut (
      .CLK_MASTER   (CLK_MASTER),
      .RESET_N      (RESET_N),
      .START        (START),
      .ABORT        (ABORT),
      .FD_INDEX_IN  (FD_INDEX_IN),
      .CKE_TIMEBASE (CKE_TIMEBASE),
      .WR_START_MASK(WR_START_MASK),
      .WR_START_NUM (WR_START_NUM),
      .WR_STOP_MASK (WR_STOP_MASK),
      .WR_STOP_NUM  (WR_STOP_NUM),
      .RD_DATA      (RD_DATA),
      .RD_VALID     (RD_VALID),
      .RD_ACK       (RD_ACK),
      .FD_WRGATE    (FD_WRGATE),
      .FD_WRDATA    (FD_WRDATA),
      .WAITING      (WAITING),
      .WRITING      (WRITING),
      .UNDERRUN     (UNDERRUN)
   );

   always #5 CLK_MASTER = ~CLK_MASTER;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic refresh_ram();
      RD_VALID = (ram.size() != 0);
      RD_DATA  = RD_VALID ? ram[0] : 8'h00;
   endtask

   task automatic load(input rec_t recs[$]);
      ram = recs;
      refresh_ram();
   endtask

   // One clock: pop the RAM on an acked edge, then sample and score outputs 1 ns later.
   task automatic step();
      pulse_t p;
      int     e;
      @(posedge CLK_MASTER);
      if (ack_pending && ram.size() > 0) void'(ram.pop_front());
      #1;
      cyc++;
      ack_pending = RD_ACK;
      refresh_ram();
      if (RD_ACK) begin
         if (exp_ack.size() > 0) e = exp_ack.pop_front();
         else e = -1;
         check("rd_ack_cycle", cyc, e);
      end
      if (FD_WRDATA && !wr_prev) begin
         if (exp_rise.size() > 0) p = exp_rise.pop_front();
         else p = '{-1, 0};
         check("pulse_rise_cycle", cyc, p.rise);
         cur_w = p.width;
         hi    = 1;
      end else if (FD_WRDATA) begin
         hi++;
      end else if (wr_prev) begin
         check("pulse_width", hi, cur_w);
      end
      wr_prev = FD_WRDATA;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic kick(output int s);
      s     = cyc;
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Reference cadence: FETCH f, RD_ACK f+1, DELAY d+1 cycles, pulse visible at f+3+d.
   task automatic plan(input int lead, input rec_t recs[$], output int fend);
      int f;
      int d;
      f = lead + int'(GL);
      foreach (recs[i]) begin
         exp_ack.push_back(f + 1);
         d = int'(recs[i] & 8'h7f);
         if (recs[i] >= 8'h80) begin
            exp_rise.push_back('{f + 3 + d, int'(PW)});
            f = f + 2 + d + int'(PW);
         end else begin
            f = f + 2 + d;
         end
      end
      fend = f;
   endtask

   task automatic all_outputs_zero(input string tag);
      check({tag, "_rd_ack"}, int'(RD_ACK), 0);
      check({tag, "_wrgate"}, int'(FD_WRGATE), 0);
      check({tag, "_wrdata"}, int'(FD_WRDATA), 0);
      check({tag, "_writing"}, int'(WRITING), 0);
      check({tag, "_waiting"}, int'(WAITING), 0);
   endtask

   initial begin
      int   s;
      int   fend;
      rec_t recs[$];
      rec_t first[$];
      rec_t none[$];

      // Reset state
      #3;
      all_outputs_zero("reset");
      check("reset_underrun", int'(UNDERRUN), 0);
      #10 RESET_N = 1'b1;
      step();
      step();

      // Immediate start, three records, stream end without index stop
      recs = '{8'h85, 8'h03, 8'h82};
      load(recs);
      kick(s);
      check("t1_waiting", int'(WAITING), 1);
      check("t1_gate_low_in_wait", int'(FD_WRGATE), 0);
      plan(s + 2, recs, fend);
      step();
      check("t1_gate_rise", int'(FD_WRGATE), 1);
      run_to(fend);
      check("t1_writing_last_fetch", int'(WRITING), 1);
      step();
      check("t1_idle_on_empty", int'(WRITING), 0);
      check("t1_underrun", int'(UNDERRUN), 0);

      // Start index counting: gate rises one cycle after the third index edge
      WR_START_MASK = 8'd1;
      WR_START_NUM  = 8'd2;
      recs = '{8'h81};
      load(recs);
      kick(s);
      check("t2_waiting", int'(WAITING), 1);
      for (int k = 0; k < 2; k++) begin
         FD_INDEX_IN = 1'b1;
         step();
         FD_INDEX_IN = 1'b0;
         step();
         step();
         check("t2_gate_before_third_index", int'(FD_WRGATE), 0);
      end
      FD_INDEX_IN = 1'b1;
      step();
      FD_INDEX_IN = 1'b0;
      check("t2_gate_after_third_index", int'(FD_WRGATE), 1);
      check("t2_waiting_cleared", int'(WAITING), 0);
      plan(cyc, recs, fend);
      run_to(fend + 1);
      check("t2_idle_after_stream", int'(WRITING), 0);
      WR_START_MASK = 8'd0;
      WR_START_NUM  = 8'd0;

      // Stop on first index during a pulse: gate falls, pulse truncated, no more pops
      WR_STOP_MASK = 8'd1;
      WR_STOP_NUM  = 8'd0;
      recs.delete();
      for (int k = 0; k < 20; k++) recs.push_back(8'h82);
      load(recs);
      first = '{8'h82};
      kick(s);
      plan(s + 2, first, fend);
      exp_rise[exp_rise.size() - 1].width = 2;
      for (int i = 0; i < 100 && !FD_WRDATA; i++) step();
      check("t3_wrdata_seen", int'(FD_WRDATA), 1);
      step();
      FD_INDEX_IN = 1'b1;
      step();
      FD_INDEX_IN = 1'b0;
      check("t3_gate_fell", int'(FD_WRGATE), 0);
      check("t3_wrdata_killed", int'(FD_WRDATA), 0);
      repeat (6) step();
      check("t3_ram_left", ram.size(), 19);
      check("t3_underrun", int'(UNDERRUN), 0);
      ram.delete();
      refresh_ram();

      // Stream runs dry with index stop armed: sticky underrun
      WR_STOP_NUM = 8'd5;
      recs = '{8'h81, 8'h01};
      load(recs);
      kick(s);
      plan(s + 2, recs, fend);
      run_to(fend);
      check("t4_underrun_before_end", int'(UNDERRUN), 0);
      step();
      check("t4_underrun_set", int'(UNDERRUN), 1);
      check("t4_idle", int'(WRITING), 0);
      repeat (3) step();
      check("t4_underrun_sticky", int'(UNDERRUN), 1);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      step();
      check("t4_underrun_after_abort", int'(UNDERRUN), 1);

      // Abort mid-DELAY; the new START clears underrun
      WR_STOP_MASK = 8'd0;
      recs  = '{8'h7f, 8'h81};
      first = '{8'h7f};
      load(recs);
      kick(s);
      check("t5_underrun_cleared", int'(UNDERRUN), 0);
      plan(s + 2, first, fend);
      run_to(s + 2 + int'(GL) + 6);
      check("t5_writing_in_delay", int'(WRITING), 1);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      step();
      all_outputs_zero("t5_abort");
      ram.delete();
      refresh_ram();

      // START and ABORT together: ABORT wins
      START = 1'b1;
      ABORT = 1'b1;
      step();
      START = 1'b0;
      ABORT = 1'b0;
      check("t5b_no_wait", int'(WAITING), 0);
      step();
      check("t5b_no_write", int'(WRITING), 0);

      // Zero-delay record, then async reset in the middle of its pulse
      recs  = '{8'h80, 8'h81};
      first = '{8'h80};
      load(recs);
      kick(s);
      plan(s + 2, first, fend);
      exp_rise[exp_rise.size() - 1].width = 1;
      run_to(s + 2 + int'(GL) + 1);
      check("t6_ack_zero_delay", int'(RD_ACK), 1);
      run_to(s + 2 + int'(GL) + 3);
      check("t6_pulse_two_after_ack", int'(FD_WRDATA), 1);
      #2 RESET_N = 1'b0;
      #1;
      all_outputs_zero("t6_async_reset");
      #2 RESET_N = 1'b1;
      ram.delete();
      refresh_ram();
      ack_pending = 1'b0;
      step();

      // Stop index and empty RAM in the same FETCH cycle: stop wins, no underrun
      WR_STOP_MASK = 8'd1;
      WR_STOP_NUM  = 8'd0;
      kick(s);
      plan(s + 2, none, fend);
      run_to(fend);
      check("t7_in_fetch", int'(WRITING), 1);
      FD_INDEX_IN = 1'b1;
      step();
      FD_INDEX_IN = 1'b0;
      check("t7_idle", int'(WRITING), 0);
      check("t7_no_underrun", int'(UNDERRUN), 0);
      repeat (3) step();

      check("pending_pulses", exp_rise.size(), 0);
      check("pending_acks", exp_ack.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
